aes_input_collector: RTL and testbench
======================================

Name: aes_input_collector

Overview:
Upstream neighbour of the AES output serializer. Accepts 32-bit words from the host bus and assembles a 128-bit key and a 128-bit plaintext/ciphertext block. Presents both to the AES core with a one-cycle load pulse. Holds off the host until the core reports done, then re-arms for the next block.

Parameters:
WORD_W, 32, host word width
BLK_W, 128, AES block and key width; must be a multiple of WORD_W
NWORDS, BLK_W/WORD_W (4), words per key or block; derived, not overridden

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid_i  input  1  host word valid
in_data_i  input  WORD_W  host word
in_ready_o  output  1  collector can accept a word this cycle
core_done_i  input  1  AES core finished current block; single-cycle pulse
ld_o  output  1  one-cycle load strobe to core
key_o  output  BLK_W  assembled key, stable from ld_o until next KEY-phase write
text_o  output  BLK_W  assembled block, stable from ld_o until next TEXT-phase write
busy_o  output  1  high from ld_o through the core_done_i cycle

Behaviour:
- Reset (async assert, sync deassert by the system): state=S_KEY, word counter=0; key_o, text_o, ld_o, busy_o all 0; in_ready_o=1 after reset releases.
- Transfer occurs on a rising edge with in_valid_i && in_ready_o.
- States:
  - S_KEY: in_ready_o=1. Transfer writes in_data_i to key_o[cnt*WORD_W +: WORD_W]; cnt increments. The transfer at cnt=NWORDS-1 wraps cnt to 0 and moves to S_TEXT.
  - S_TEXT: same as S_KEY, writing text_o. The last word moves to S_LOAD.
  - S_LOAD: in_ready_o=0, ld_o=1 for exactly one cycle, busy_o=1. Next state is S_BUSY.
  - S_BUSY: in_ready_o=0, busy_o=1. When core_done_i=1, move to S_KEY with busy_o=0 the following cycle.
- Word order: the first word is written to bits [31:0], the last to [127:96]. This matches the downstream serializer's order.
- Latency: ld_o is high in the cycle after the 8th accepted word. Minimum block period is 8 transfers + 1 load cycle + core time + 1.
- in_valid_i low in S_KEY/S_TEXT: hold state and cnt; no bubble penalty.
- in_valid_i high while in_ready_o=0: ignored, nothing written. The host must hold the word.
- core_done_i outside S_BUSY: ignored.
- core_done_i in the same cycle as ld_o (S_LOAD): ignored. Done is only honoured in S_BUSY.
- Reset mid-block: partially written key/text cleared to 0, cnt=0, state=S_KEY. No ld_o is emitted for the aborted block.
- Registers are written only on transfer, so key_o and text_o do not glitch between words.

Optional Feature:
AES_INBUF_KEY_HOLD_EN
- Defined: adds input port key_hold_i (1 bit), sampled when leaving S_BUSY and at reset release.
  - If key_hold_i=1, the next state is S_TEXT instead of S_KEY, and key_o keeps its previous value.
  - After reset, key_o=0 regardless, so the first block with key_hold_i=1 uses an all-zero key.
- Not defined: port absent; every block loads 4 key words then 4 text words.

Decomposition:
- Package aes_pkg:
  - constants AES_BLK_W=128, AES_WORD_W=32, AES_NWORDS=4
  - typedef enum logic [1:0] {S_KEY, S_TEXT, S_LOAD, S_BUSY} aes_in_state_t
  - typedef logic [127:0] aes_blk_t
- One natural sub-module: aes_word_packer. It holds one BLK_W register with a word-indexed write enable and is instantiated twice, for key and text. The FSM and counter stay in the top module.

Test Plan:
1. Reset, then words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C (key), then 0x33221100, 0x77665544, 0xBBAA9988, 0xFFEEDDCC (text), back-to-back -> next cycle ld_o=1 for 1 cycle; key_o=0x0F0E0D0C_0B0A0908_07060504_03020100; text_o=0xFFEEDDCC_BBAA9988_77665544_33221100.
2. Same 8 words with in_valid_i toggling 1/0 each cycle -> identical key_o/text_o; ld_o asserts once, the cycle after the 8th transfer.
3. After ld_o, hold in_valid_i=1 with data 0xDEADBEEF for 20 cycles, then pulse core_done_i -> in_ready_o=0 throughout; key_o/text_o unchanged; in_ready_o=1 and busy_o=0 the cycle after done.
4. Assert rst after 5 accepted words -> key_o=text_o=0, ld_o never asserts. A subsequent full 8-word sequence loads correctly.
5. Pulse core_done_i in S_KEY and in S_LOAD -> no state change; busy_o stays high until a done pulse in S_BUSY.
6. With AES_INBUF_KEY_HOLD_EN defined: load block 1 as in test 1; after done, key_hold_i=1, send 4 text words 0x11111111 -> ld_o after the 4th word; key_o unchanged from test 1.

Source files
------------

// File: rtl/aes_input_collector_pkg.sv
// Shared types and constants for the AES input collector.
// Optional feature macro used by the collector: AES_INBUF_KEY_HOLD_EN.
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;
    localparam int AES_NWORDS = AES_BLK_W / AES_WORD_W;

    typedef enum logic [1:0] {
        S_KEY  = 2'd0,
        S_TEXT = 2'd1,
        S_LOAD = 2'd2,
        S_BUSY = 2'd3
    } aes_in_state_t;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    // True in the phases where the host may hand over words.
    function automatic logic accepts_words(input aes_in_state_t st);
        logic acc;
        case (st)
            S_KEY:   acc = 1'b1;
            S_TEXT:  acc = 1'b1;
            S_LOAD:  acc = 1'b0;
            S_BUSY:  acc = 1'b0;
            default: acc = 1'b0;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/aes_input_collector_word_packer.sv
// One block-wide register assembled word by word. A write updates only the
// addressed word, so the untouched words never glitch between transfers.
module aes_word_packer
    import aes_pkg::*;
#(
    parameter int WORD_W = AES_WORD_W,
    parameter int NWORDS = AES_NWORDS,
    parameter int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [IDX_W-1:0]         idx_i,
    input  logic [WORD_W-1:0]        data_i,
    output logic [NWORDS*WORD_W-1:0] blk_o
);

    logic [NWORDS*WORD_W-1:0] blk_d;
    logic [NWORDS*WORD_W-1:0] blk_q;

    // Merge the incoming word into its slot; all other slots keep their value.
    always_comb begin
        blk_d = blk_q;
        for (int i = 0; i < NWORDS; i++) begin
            if (we_i && (idx_i == IDX_W'(i))) begin
                blk_d[i*WORD_W +: WORD_W] = data_i;
            end else begin
                blk_d[i*WORD_W +: WORD_W] = blk_q[i*WORD_W +: WORD_W];
            end
        end
    end

    // Block register, cleared by reset so an aborted block leaves no residue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign blk_o = blk_q;

endmodule

// File: rtl/aes_input_collector.sv
// AES input collector: gathers host words into a key and a text block, fires
// a one-cycle load strobe to the core and holds the host off until the core
// reports done.
// Optional feature macro: AES_INBUF_KEY_HOLD_EN adds key_hold_i, which lets a
// block reuse the previous key and skip straight to the text words.
module aes_input_collector
    import aes_pkg::*;
#(
    parameter int WORD_W = AES_WORD_W,
    parameter int BLK_W  = AES_BLK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              core_done_i,
`ifdef AES_INBUF_KEY_HOLD_EN
    input  logic              key_hold_i,
`endif
    output logic              ld_o,
    output logic [BLK_W-1:0]  key_o,
    output logic [BLK_W-1:0]  text_o,
    output logic              busy_o
);

    localparam int NWORDS = BLK_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    aes_in_state_t    state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             ld_d, ld_q;
    logic             busy_d, busy_q;
    logic             in_ready_d, in_ready_q;

    logic             xfer_s;
    logic             last_s;
    logic             text_phase_s;
    logic             key_we_s;
    logic             text_we_s;
    logic             hold_key_s;

`ifdef AES_INBUF_KEY_HOLD_EN
    // First cycle after reset release: key_hold_i is sampled here too.
    logic             init_d, init_q;
    assign hold_key_s   = key_hold_i;
    assign text_phase_s = (state_q == S_TEXT) ||
                          ((state_q == S_KEY) && init_q && key_hold_i);
`else
    assign hold_key_s   = 1'b0;
    assign text_phase_s = (state_q == S_TEXT);
`endif

    assign xfer_s = in_valid_i && in_ready_q;
    assign last_s = (cnt_q == CNT_W'(NWORDS - 1));

    // Next-state, word counter and write-enable decode for the collector FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_we_s  = 1'b0;
        text_we_s = 1'b0;
        case (state_q)
            S_KEY, S_TEXT: begin
                if (xfer_s) begin
                    if (last_s) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (text_phase_s) begin
                        text_we_s = 1'b1;
                        state_d   = last_s ? S_LOAD : S_TEXT;
                    end else begin
                        key_we_s  = 1'b1;
                        state_d   = last_s ? S_TEXT : S_KEY;
                    end
                end else begin
                    // No word this cycle: hold, except that a key hold at
                    // reset release moves the collector into the text phase.
                    state_d = text_phase_s ? S_TEXT : state_q;
                end
            end
            S_LOAD: begin
                // Done in the load cycle is deliberately not looked at.
                state_d = S_BUSY;
                cnt_d   = '0;
            end
            S_BUSY: begin
                cnt_d = '0;
                if (core_done_i) begin
                    state_d = hold_key_s ? S_TEXT : S_KEY;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: begin
                state_d = S_KEY;
                cnt_d   = '0;
            end
        endcase
    end

    // Output flags derived from the next state so they line up with it.
    always_comb begin
        ld_d       = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD) || (state_d == S_BUSY);
        in_ready_d = accepts_words(state_d);
    end

`ifdef AES_INBUF_KEY_HOLD_EN
    // Init marker is true only for the first cycle after reset.
    always_comb begin
        init_d = 1'b0;
    end

    // Init marker register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q <= 1'b1;
        end else begin
            init_q <= init_d;
        end
    end
`endif

    // FSM state, counter and registered handshake/strobe outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_KEY;
            cnt_q      <= '0;
            ld_q       <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ld_q       <= ld_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    aes_word_packer #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS),
        .IDX_W  (CNT_W)
    ) u_key_packer (
        .clk    (clk),
        .rst    (rst),
        .we_i   (key_we_s),
        .idx_i  (cnt_q),
        .data_i (in_data_i),
        .blk_o  (key_o)
    );

    aes_word_packer #(
        .WORD_W (WORD_W),
        .NWORDS (NWORDS),
        .IDX_W  (CNT_W)
    ) u_text_packer (
        .clk    (clk),
        .rst    (rst),
        .we_i   (text_we_s),
        .idx_i  (cnt_q),
        .data_i (in_data_i),
        .blk_o  (text_o)
    );

    assign ld_o       = ld_q;
    assign busy_o     = busy_q;
    assign in_ready_o = in_ready_q;

endmodule

// File: tb/tb_aes_input_collector.sv
// Directed, scoreboard-based bench for aes_input_collector.
// Define AES_INBUF_KEY_HOLD_EN to also exercise the key-hold feature.
module tb_aes_input_collector;
    import aes_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic [31:0] in_data_i;
    logic        in_ready_o;
    logic        core_done_i;
    logic        ld_o;
    logic [127:0] key_o;
    logic [127:0] text_o;
    logic        busy_o;
`ifdef AES_INBUF_KEY_HOLD_EN
    logic        key_hold_i;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ld_cnt   = 0;
    aes_blk_t exp_key_q[$];
    aes_blk_t exp_text_q[$];

    logic [31:0] kw[4];
    logic [31:0] tw[4];

    always #5 clk = ~clk;

    aes_input_collector dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .core_done_i (core_done_i),
`ifdef AES_INBUF_KEY_HOLD_EN
        .key_hold_i  (key_hold_i),
`endif
        .ld_o        (ld_o),
        .key_o       (key_o),
        .text_o      (text_o),
        .busy_o      (busy_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 ns after the edge and score any load strobe.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ld_o === 1'b1) begin
            ld_cnt++;
            if (exp_key_q.size() == 0) begin
                chk("ld_unexpected", 128'(ld_o), 128'd0);
            end else begin
                chk("ld_key", key_o, exp_key_q.pop_front());
                chk("ld_text", text_o, exp_text_q.pop_front());
            end
        end
    endtask

    // Offer one word and hold it until the collector takes it (bounded).
    task automatic send_word(input logic [31:0] w);
        logic accepted;
        accepted   = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = w;
        for (int t = 0; t < 200; t++) begin
            accepted = in_ready_o;
            tick();
            if (accepted) break;
        end
        in_valid_i = 1'b0;
        chk("accept", 128'(accepted), 128'd1);
    endtask

    task automatic send_block(input logic [127:0] ek, input logic do_key,
                              input logic gap);
        exp_key_q.push_back(ek);
        exp_text_q.push_back({tw[3], tw[2], tw[1], tw[0]});
        if (do_key) begin
            for (int i = 0; i < 4; i++) begin
                send_word(kw[i]);
                if (gap) tick();
            end
        end
        for (int i = 0; i < 4; i++) begin
            send_word(tw[i]);
            if (gap && i != 3) tick();
        end
    endtask

    task automatic pulse_done();
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_key", key_o, 128'd0);
        chk("rst_text", text_o, 128'd0);
        chk("rst_ld", 128'(ld_o), 128'd0);
        chk("rst_busy", 128'(busy_o), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_ready", 128'(in_ready_o), 128'd1);
    endtask

    initial begin
        int       ld_before;
        logic     any_ready;
        logic [127:0] k1, t1;
        rst         = 1'b1;
        in_valid_i  = 1'b0;
        in_data_i   = 32'h0;
        core_done_i = 1'b0;
`ifdef AES_INBUF_KEY_HOLD_EN
        key_hold_i  = 1'b0;
`endif
        kw = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        tw = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
        k1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        t1 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

        // 1: reset, then back-to-back block
        repeat (2) @(posedge clk);
        do_reset();
        ld_before = ld_cnt;
        send_block(k1, 1'b1, 1'b0);
        chk("t1_ld_now", 128'(ld_o), 128'd1);
        chk("t1_ld_once", 128'(ld_cnt - ld_before), 128'd1);
        tick();
        chk("t1_ld_single", 128'(ld_o), 128'd0);
        chk("t1_busy", 128'(busy_o), 128'd1);

        // 3: hold a word offered while busy, then release with done
        in_valid_i = 1'b1;
        in_data_i  = 32'hDEADBEEF;
        any_ready  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready_o !== 1'b0) any_ready = 1'b1;
            tick();
        end
        chk("t3_ready_low", 128'(any_ready), 128'd0);
        chk("t3_key_held", key_o, k1);
        chk("t3_text_held", text_o, t1);
        in_valid_i = 1'b0;
        pulse_done();
        chk("t3_ready_after", 128'(in_ready_o), 128'd1);
        chk("t3_busy_after", 128'(busy_o), 128'd0);
        chk("t3_key_after", key_o, k1);

        // 2: same words, valid toggling
        ld_before = ld_cnt;
        send_block(k1, 1'b1, 1'b1);
        chk("t2_ld_now", 128'(ld_o), 128'd1);
        chk("t2_ld_once", 128'(ld_cnt - ld_before), 128'd1);
        tick();
        pulse_done();

        // 4: reset after 5 accepted words
        ld_before = ld_cnt;
        for (int i = 0; i < 4; i++) send_word(kw[i]);
        send_word(32'hA5A5A5A5);
        do_reset();
        repeat (3) tick();
        chk("t4_no_ld", 128'(ld_cnt - ld_before), 128'd0);
        kw = '{32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040};
        tw = '{32'h50505050, 32'h60606060, 32'h70707070, 32'h80808080};
        send_block(128'h40404040_30303030_20202020_10101010, 1'b1, 1'b0);
        chk("t4_reload_ld", 128'(ld_cnt - ld_before), 128'd1);
        tick();
        pulse_done();

        // 5: done ignored in S_KEY and in S_LOAD
        pulse_done();
        chk("t5_key_ready", 128'(in_ready_o), 128'd1);
        chk("t5_key_busy", 128'(busy_o), 128'd0);
        kw = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        tw = '{32'h33221100, 32'h77665544, 32'hBBAA9988, 32'hFFEEDDCC};
        send_block(k1, 1'b1, 1'b0);
        chk("t5_in_load", 128'(ld_o), 128'd1);
        pulse_done();
        chk("t5_busy_after_load_done", 128'(busy_o), 128'd1);
        repeat (3) tick();
        chk("t5_still_busy", 128'(busy_o), 128'd1);
        pulse_done();
        chk("t5_busy_cleared", 128'(busy_o), 128'd0);

`ifdef AES_INBUF_KEY_HOLD_EN
        // 6: key hold reuses the previous key
        ld_before = ld_cnt;
        send_block(k1, 1'b1, 1'b0);
        tick();
        key_hold_i = 1'b1;
        pulse_done();
        key_hold_i = 1'b0;
        tw = '{32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111};
        send_block(k1, 1'b0, 1'b0);
        chk("t6_ld_now", 128'(ld_o), 128'd1);
        chk("t6_ld_count", 128'(ld_cnt - ld_before), 128'd2);
        chk("t6_key_kept", key_o, k1);
        tick();
        pulse_done();
`endif

        chk("sb_empty", 128'(exp_key_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
